logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, 2-stage pipelined bitwise logic unit; successor to the fixed 32-bit AND/OR/NOT gates.
//  Adds runtime op select (AND/OR/XOR/NOR/NOT/ANDN/PASS) and valid/ready handshakes on both sides.
//  Sits beside the ALU in the EX stage; absorbs back-pressure without dropping or duplicating results.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=1)
//  OPW     3   op-select width; fixed by lu_pkg, not to be overridden
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      operand beat offered
//  in_ready   out  1      unit accepts beat this cycle
//  in_op      in   OPW    operation select (lu_pkg encoding)
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B (ignored by NOT/PASS)
//  out_valid  out  1      result beat available
//  out_ready  in   1      consumer takes result this cycle
//  out_res    out  WIDTH  result
//  out_zero   out  1      result==0 (LU_FLAGS_EN only)
//  out_par    out  1      XOR-reduce of result (LU_FLAGS_EN only)
// BEHAVIOUR
//  - Op encoding: 000 A&B, 001 A|B, 010 A^B, 011 ~(A|B), 100 ~A, 101 A&~B, 110 A, 111 reserved -> all-zero result.
//  - Stage 1 (S1): registers op/A/B with s1_valid. Stage 2 (S2): registers computed result with s2_valid.
//  - Transfer: in accepted iff in_valid&in_ready; out consumed iff out_valid&out_ready.
//  - s2_adv = s1_valid & (~s2_valid | out_ready); in_ready = ~reset & (~s1_valid | s2_adv).
//  - Latency: beat accepted at edge N -> out_valid at edge N+2 (no stall). Throughput 1 beat/cycle.
//  - out_valid/out_res/flags held stable while out_valid & ~out_ready; may change only after consume.
//  - Simultaneous accept + consume with both stages full: all three move in the same edge; no bubble.
//  - Full pipe (s1_valid & s2_valid) with out_ready=0: in_ready=0; S1 and S2 hold.
//  - Order preserved; no drop, no duplication.
//  - Reset: s1_valid=0, s2_valid=0, out_valid=0, out_res=0, flags=0, in_ready=0 while reset high.
//    Reset mid-operation discards in-flight beats; first accept possible on cycle after reset deasserts.
//  - Data registers may hold stale values when invalid; only valid-qualified data is meaningful.
//  - No arithmetic; all ops width-exact, no carry, no sign extension.
// CONFIGURATION
//  - Macro LU_FLAGS_EN defined: out_zero and out_par ports exist; computed from the S1 result, registered
//    into S2 with out_res, same stall/hold rules, reset to 0.
//  - LU_FLAGS_EN undefined: ports and flag registers absent; result path identical.
// STRUCTURE
//  - lu_pkg: OPW, LU_AND..LU_PASS op localparams, LU_RSVD; shared with decoder/control.
//  - Sub-module lu_pipe_reg (parametrised width, valid + load-enable register, sync reset of valid) instantiated for S1 and S2.
//  - Op mux is combinational between S1 and S2; no logic after S2 register.
// TESTING (WIDTH=32)
//  - Each op, A=F0F0_1234 B=0FF0_FFFF, out_ready=1 -> results 00F0_1234, FFF0_FFFF, FF00_EDCB, 000F_0000, 0F0F_EDCB, F000_0000, F0F0_1234; reserved op 111 -> 0000_0000; each 2 cycles after accept.
//  - Streaming 8 back-to-back beats, out_ready=1 -> 8 results on consecutive cycles, in order, in_ready never drops.
//  - out_ready=0 for 5 cycles mid-stream -> in_ready falls after 2 accepts, out_res held constant; release -> no loss/dup.
//  - Random in_valid/out_ready 10k beats vs. scoreboard -> exact match, in order.
//  - Reset asserted with both stages full -> next cycle out_valid=0, in_ready=0; after deassert first new beat emerges 2 cycles post-accept.
//  - LU_FLAGS_EN: XOR with A=B=5A5A_5A5A -> out_zero=1,out_par=0; OR A=0000_0001 B=0 -> out_zero=0,out_par=1.

Source files
------------

// File: rtl/lu_pkg.sv
// Shared definitions for the bitwise logic unit: op-select width and the
// op encoding used by the decoder, control and the pipelined unit.
`timescale 1ns/1ps
package lu_pkg;

  localparam int OPW = 3;

  localparam logic [OPW-1:0] LU_AND  = 3'b000;
  localparam logic [OPW-1:0] LU_OR   = 3'b001;
  localparam logic [OPW-1:0] LU_XOR  = 3'b010;
  localparam logic [OPW-1:0] LU_NOR  = 3'b011;
  localparam logic [OPW-1:0] LU_NOT  = 3'b100;
  localparam logic [OPW-1:0] LU_ANDN = 3'b101;
  localparam logic [OPW-1:0] LU_PASS = 3'b110;
  localparam logic [OPW-1:0] LU_RSVD = 3'b111;

endpackage

// File: rtl/lu_pipe_reg.sv
// One pipeline slot: a valid bit plus a data word, both loaded on ld.
// The valid bit always clears on reset; the data word clears on reset only
// when RST_DATA is set (used where the data is visible at the unit outputs).
`timescale 1ns/1ps
module lu_pipe_reg #(
  parameter int WIDTH    = 32,
  parameter bit RST_DATA = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic             vld_in,
  input  logic [WIDTH-1:0] d,
  output logic             vld,
  output logic [WIDTH-1:0] q
);

  // Valid bit: cleared by reset, otherwise follows the upstream valid on load
  always_ff @(posedge clk) begin
    if (reset)   vld <= 1'b0;
    else if (ld) vld <= vld_in;
  end

  // Data word: loaded alongside the valid bit, stale contents allowed when invalid
  always_ff @(posedge clk) begin
    if (RST_DATA && reset) q <= '0;
    else if (ld)           q <= d;
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready on both sides.
// S1 captures op/A/B, the op mux sits between S1 and S2, S2 drives the outputs
// directly. Optional zero/parity flags are built when LU_FLAGS_EN is defined.
`timescale 1ns/1ps
module logic_unit_pipe
  import lu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res
`ifdef LU_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_par
`endif
);

  localparam int S1W = OPW + 2 * WIDTH;
`ifdef LU_FLAGS_EN
  localparam int S2W = WIDTH + 2;
`else
  localparam int S2W = WIDTH;
`endif

  logic             vld_p1;
  logic             vld_p2;
  logic             ld_p2;
  logic             s2_adv;
  logic [S1W-1:0]   q_p1;
  logic [OPW-1:0]   op_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [WIDTH-1:0] res_p1;
  logic [S2W-1:0]   d_p2;
  logic [S2W-1:0]   q_p2;

  function automatic logic [WIDTH-1:0] lu_eval(input logic [OPW-1:0]   op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      LU_AND:  return a & b;
      LU_OR:   return a | b;
      LU_XOR:  return a ^ b;
      LU_NOR:  return ~(a | b);
      LU_NOT:  return ~a;
      LU_ANDN: return a & ~b;
      LU_PASS: return a;
      default: return '0;
    endcase
  endfunction

  // S2 loads whenever it is empty or its result is being consumed; S1 can take
  // a new beat whenever it is empty or its beat moves on to S2 this edge.
  assign ld_p2    = ~vld_p2 | out_ready;
  assign s2_adv   = vld_p1 & ld_p2;
  assign in_ready = ~reset & (~vld_p1 | s2_adv);

  // ---- stage boundary: inputs -> S1 (op, A, B) ----
  lu_pipe_reg #(
    .WIDTH    (S1W),
    .RST_DATA (1'b0)
  ) u_s1 (
    .clk    (clk),
    .reset  (reset),
    .ld     (in_ready),
    .vld_in (in_valid),
    .d      ({in_op, in_a, in_b}),
    .vld    (vld_p1),
    .q      (q_p1)
  );

  assign {op_p1, a_p1, b_p1} = q_p1;

  // Op mux between S1 and S2
  always_comb begin
    res_p1 = lu_eval(op_p1, a_p1, b_p1);
  end

`ifdef LU_FLAGS_EN
  assign d_p2 = {~|res_p1, ^res_p1, res_p1};
`else
  assign d_p2 = res_p1;
`endif

  // ---- stage boundary: S1 -> S2 (result, flags) ----
  lu_pipe_reg #(
    .WIDTH    (S2W),
    .RST_DATA (1'b1)
  ) u_s2 (
    .clk    (clk),
    .reset  (reset),
    .ld     (ld_p2),
    .vld_in (vld_p1),
    .d      (d_p2),
    .vld    (vld_p2),
    .q      (q_p2)
  );

  assign out_valid = vld_p2;
  assign out_res   = q_p2[WIDTH-1:0];
`ifdef LU_FLAGS_EN
  assign out_zero  = q_p2[WIDTH+1];
  assign out_par   = q_p2[WIDTH];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomised bench for logic_unit_pipe (WIDTH=32): op results and
// latency, streaming, stall/hold, reset flush, random handshakes vs. scoreboard.
// Flag checks are included when LU_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
`ifdef LU_FLAGS_EN
  logic        out_zero;
  logic        out_par;
`endif

  int nchk = 0;
  int nerr = 0;

  logic [31:0] q[$];
  logic        acc;
  logic        cons;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_res  = '0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res)
`ifdef LU_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_par   (out_par)
`endif
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lu_model(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~a & ~b;
      3'd4: return ~a;
      3'd5: return a & ~b;
      3'd6: return a;
      default: return 32'h0;
    endcase
  endfunction

  // One handshake cycle: drive at negedge, sample, score the coming edge.
  task automatic cyc(input logic iv, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    #1;
    if (prev_hold) begin
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_res", {32'd0, out_res}, {32'd0, prev_res});
    end
    acc  = in_valid & in_ready;
    cons = out_valid & out_ready;
    if (cons) begin
      if (q.size() == 0) chk("spurious_out", {63'd0, out_valid}, 64'd0);
      else               chk("order_res", {32'd0, out_res}, {32'd0, q.pop_front()});
    end
    if (acc) q.push_back(lu_model(op, a, b));
    prev_hold = out_valid & ~out_ready;
    prev_res  = out_res;
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while (q.size() != 0 && g < 50) begin
      cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      g++;
    end
    chk({tag, "_left"}, 64'(q.size()), 64'd0);
  endtask

  // Isolated beat through an empty pipe: result visible after exactly two edges.
  task automatic lat_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "_v1"}, {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    #1 chk({tag, "_v2"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_res"}, {32'd0, out_res}, {32'd0, exp});
    @(negedge clk);
    #1 chk({tag, "_v3"}, {63'd0, out_valid}, 64'd0);
  endtask

`ifdef LU_FLAGS_EN
  task automatic flag_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic ez, input logic ep);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 chk({tag, "_v"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_zero"}, {63'd0, out_zero}, {63'd0, ez});
    chk({tag, "_par"}, {63'd0, out_par}, {63'd0, ep});
    @(negedge clk);
  endtask
`endif

  logic [31:0] exp_ops [8] = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'hFF00_EDCB, 32'h000F_0000,
                               32'h0F0F_EDCB, 32'hF000_0000, 32'hF0F0_1234, 32'h0000_0000};

  initial begin
    int sent;
    int guard;
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_res", {32'd0, out_res}, 64'd0);
`ifdef LU_FLAGS_EN
    chk("rst_zero", {63'd0, out_zero}, 64'd0);
    chk("rst_par", {63'd0, out_par}, 64'd0);
`endif
    reset = 1'b0;

    // Every op on the reference operands, including the reserved code
    for (int i = 0; i < 8; i++)
      lat_check($sformatf("op%0d", i), 3'(i), 32'hF0F0_1234, 32'h0FF0_FFFF, exp_ops[i]);

    // Eight back-to-back beats, consumer always ready
    for (int k = 1; k <= 10; k++) begin
      if (k <= 8) cyc(1'b1, 3'(k % 7), 32'h1111_1111 * k, 32'hA5A5_0000 ^ 32'(k), 1'b1);
      else        cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      if (k <= 8) chk($sformatf("strm_rdy%0d", k), {63'd0, in_ready}, 64'd1);
      chk($sformatf("strm_cons%0d", k), {63'd0, cons}, {63'd0, (k >= 3 && k <= 10)});
    end
    drain("strm");

    // Consumer stalls for 5 cycles while the producer keeps offering
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1, 3'd2, 32'h0F0F_0000 + 32'(k), 32'h3333_3333, 1'b0);
      chk($sformatf("stall_acc%0d", k), {63'd0, acc}, {63'd0, (k <= 2)});
    end
    for (int k = 1; k <= 3; k++) cyc(1'b1, 3'd5, 32'hFFFF_0000 | 32'(k), 32'h00FF_00FF, 1'b1);
    drain("stall");

    // Reset with both stages full discards in-flight beats
    cyc(1'b1, 3'd1, 32'h1, 32'h2, 1'b0);
    cyc(1'b1, 3'd1, 32'h4, 32'h8, 1'b0);
    cyc(1'b1, 3'd1, 32'h10, 32'h20, 1'b0);
    chk("full_no_acc", {63'd0, acc}, 64'd0);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1;
    #1 chk("rstmid_rdy", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    #1;
    chk("rstmid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rstmid_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rstmid_out_res", {32'd0, out_res}, 64'd0);
    reset = 1'b0; in_valid = 1'b0;
    q.delete();
    prev_hold = 1'b0;
    lat_check("post_rst", 3'd2, 32'hDEAD_BEEF, 32'h0000_FFFF, 32'hDEAD_4110);

`ifdef LU_FLAGS_EN
    flag_check("flag_xor", 3'd2, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b1, 1'b0);
    flag_check("flag_or", 3'd1, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1);
`endif

    // Random handshakes on both sides against the scoreboard
    sent = 0;
    guard = 0;
    while (sent < 10000 && guard < 60000) begin
      cyc($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
          $urandom_range(0, 3) != 0);
      if (acc) sent++;
      guard++;
    end
    chk("rand_sent", 64'(sent), 64'd10000);
    drain("rand");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
